// File: rtl/fsm_100111001_seq_generator.sv
// ============================================================================
// Module   : fsm_100111001_seq_generator
// Brief    : Free-running Moore FSM emitting the pattern 100111001 serially,
//            MSB first. It also assembles the emitted bits into a parallel
//            word, flags each completed pattern and exposes its state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_100111001_seq_generator #(
  parameter logic [8:0] SEQ = 9'b100111001
) (
  input  logic       clk,
  input  logic       rst,          // asynchronous, active-low
  output logic [8:0] seq_out,
  output logic       seq_done,
  output logic       serial_out,
  output logic [3:0] state_out
);

  // State codes: one state per pattern bit, named after the bit emitted.
  localparam logic [3:0] c_IDLE = 4'd0;
  localparam logic [3:0] c_B8   = 4'd1;
  localparam logic [3:0] c_B7   = 4'd2;
  localparam logic [3:0] c_B6   = 4'd3;
  localparam logic [3:0] c_B5   = 4'd4;
  localparam logic [3:0] c_B4   = 4'd5;
  localparam logic [3:0] c_B3   = 4'd6;
  localparam logic [3:0] c_B2   = 4'd7;
  localparam logic [3:0] c_B1   = 4'd8;
  localparam logic [3:0] c_B0   = 4'd9;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_serial;
  logic       w_active;
  logic [8:0] r_seq;
  logic       r_done;

  // State register: asynchronous active-low reset back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: walk B8..B0, wrap B0 back to B8, recover illegal codes.
  always_comb begin
    w_next_state = c_IDLE;
    case (r_state)
      c_IDLE:  w_next_state = c_B8;
      c_B8:    w_next_state = c_B7;
      c_B7:    w_next_state = c_B6;
      c_B6:    w_next_state = c_B5;
      c_B5:    w_next_state = c_B4;
      c_B4:    w_next_state = c_B3;
      c_B3:    w_next_state = c_B2;
      c_B2:    w_next_state = c_B1;
      c_B1:    w_next_state = c_B0;
      c_B0:    w_next_state = c_B8;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output decode: the serial bit depends on state only (Moore).
  always_comb begin
    w_serial = 1'b0;
    w_active = 1'b1;
    case (r_state)
      c_B8:    w_serial = SEQ[8];
      c_B7:    w_serial = SEQ[7];
      c_B6:    w_serial = SEQ[6];
      c_B5:    w_serial = SEQ[5];
      c_B4:    w_serial = SEQ[4];
      c_B3:    w_serial = SEQ[3];
      c_B2:    w_serial = SEQ[2];
      c_B1:    w_serial = SEQ[1];
      c_B0:    w_serial = SEQ[0];
      default: begin
        // IDLE and illegal codes emit 0 and freeze the capture register.
        w_serial = 1'b0;
        w_active = 1'b0;
      end
    endcase
  end

  // Capture register: shift in the bit being emitted while a pattern runs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seq <= 9'h000;
    end else if (w_active) begin
      r_seq <= {r_seq[7:0], w_serial};
    end
  end

  // Completion flag: leaving B0 is exactly when the capture holds a full
  // pattern, so the pulse lines up with seq_out first equalling SEQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == c_B0);
    end
  end

  assign seq_out    = r_seq;
  assign seq_done   = r_done;
  assign serial_out = w_serial;
  assign state_out  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fsm_100111001_seq_generator.sv
// ============================================================================
// Module   : tb_fsm_100111001_seq_generator
// Brief    : Self-checking bench for fsm_100111001_seq_generator. A pattern
//            model driven by the count of edges since reset release is
//            compared every cycle, alongside directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_100111001_seq_generator;

  logic       clk;
  logic       rst;
  logic [8:0] seq_out;
  logic       seq_done;
  logic       serial_out;
  logic [3:0] state_out;

  int errors;
  int checks;
  int k;            // rising edges seen since reset release
  bit model_on;

  fsm_100111001_seq_generator dut (
    .clk        (clk),
    .rst        (rst),
    .seq_out    (seq_out),
    .seq_done   (seq_done),
    .serial_out (serial_out),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: position in the endless stream, derived from edge count alone.
  function automatic int m_state(input int n);
    return (n == 0) ? 0 : ((n - 1) % 9) + 1;
  endfunction

  function automatic int m_serial(input int n);
    logic [8:0] pat = 9'b100111001;
    int s = m_state(n);
    return (s == 0) ? 0 : int'(pat[9 - s]);
  endfunction

  // Bits captured so far = edges after the first; stream bit j is pat[8 - j%9].
  function automatic int m_seq(input int n);
    logic [8:0] pat = 9'b100111001;
    logic [8:0] v = '0;
    int cnt = (n - 1 > 9) ? 9 : n - 1;
    for (int i = 0; i < cnt; i++) v[i] = pat[8 - ((n - 2 - i) % 9)];
    return int'(v);
  endfunction

  function automatic int m_done(input int n);
    return (n >= 10 && ((n - 1) % 9) == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) k = 0;
    else      k = k + 1;
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("model_state",  int'(state_out),  m_state(k));
      chk("model_serial", int'(serial_out), m_serial(k));
      chk("model_seq",    int'(seq_out),    m_seq(k));
      chk("model_done",   int'(seq_done),   m_done(k));
    end
  end

  initial begin
    int exp_bits[9] = '{1, 0, 0, 1, 1, 1, 0, 0, 1};
    int last_pulse;
    int found;
    errors = 0;
    checks = 0;
    k = 0;
    model_on = 1'b0;

    // Reset hold for two cycles.
    rst = 1'b1;
    #1 rst = 1'b0;
    model_on = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_state",  int'(state_out),  0);
      chk("rst_serial", int'(serial_out), 0);
      chk("rst_seq",    int'(seq_out),    0);
      chk("rst_done",   int'(seq_done),   0);
    end

    // Release and observe the first pattern.
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      chk("first_state",  int'(state_out),  i + 1);
      chk("first_serial", int'(serial_out), exp_bits[i]);
      chk("first_done",   int'(seq_done),   0);
    end

    // 10th edge: wrapped to B8 with the completed word flagged.
    @(negedge clk); #1;
    chk("cmp_state", int'(state_out), 1);
    chk("cmp_done",  int'(seq_done),  1);
    chk("cmp_seq",   int'(seq_out),   'h139);
    @(negedge clk); #1;
    chk("cmp_done_width", int'(seq_done), 0);

    // Periodicity: every pulse carries the pattern, pulses are 9 apart.
    last_pulse = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (seq_done) begin
        chk("per_seq", int'(seq_out), 'h139);
        if (last_pulse >= 0) chk("per_gap", c - last_pulse, 9);
        last_pulse = c;
      end
    end
    chk("per_seen", int'(last_pulse >= 0), 1);

    // Mid-pattern asynchronous reset while in state 5.
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk); #1;
      if (state_out == 4'd5) found = 1;
    end
    chk("wait_state5", found, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_state",  int'(state_out),  0);
    chk("async_serial", int'(serial_out), 0);
    chk("async_seq",    int'(seq_out),    0);
    chk("async_done",   int'(seq_done),   0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("restart_state",  int'(state_out),  1);
    chk("restart_serial", int'(serial_out), 1);
    found = 0;
    for (int e = 2; e <= 15 && found == 0; e++) begin
      @(negedge clk); #1;
      if (seq_done) begin
        found = e;
        chk("restart_seq", int'(seq_out), 'h139);
      end
    end
    chk("restart_done_edge", found, 10);

    // Illegal state recovery; the model no longer applies from here.
    model_on = 1'b0;
    @(negedge clk);
    force dut.r_state = 4'd12;
    #1 release dut.r_state;
    chk("ill_state",  int'(state_out),  12);
    chk("ill_serial", int'(serial_out), 0);
    @(negedge clk); #1;
    chk("ill_recover_idle", int'(state_out), 0);
    @(negedge clk); #1;
    chk("ill_recover_b8",   int'(state_out), 1);
    chk("ill_recover_bit",  int'(serial_out), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
